// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: FSM states,
// opcodes, datapath mux selects and ALU control derived from the opcode.
package cpu_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLI  = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    localparam logic [1:0] PC_PLUS1  = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_SHL = 2'b10;
    localparam logic [1:0] ALU_IMM = 2'b11;

    typedef struct packed {
        logic [1:0] op;
        logic       src;
        logic       sext;
    } alu_ctl_t;

    // Jumps still drive a benign add so the ALU inputs never float.
    function automatic alu_ctl_t alu_ctl(input logic [2:0] opcode);
        alu_ctl_t c;
        case (opcode)
            OP_SLI:                 c = '{op: ALU_SHL, src: 1'b1, sext: 1'b0};
            OP_BEQ:                 c = '{op: ALU_SUB, src: 1'b0, sext: 1'b1};
            OP_LW, OP_SW, OP_ADDI:  c = '{op: ALU_IMM, src: 1'b1, sext: 1'b1};
            default:                c = '{op: ALU_ADD, src: 1'b0, sext: 1'b1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_mem_wait_timer.sv
// Wait-cycle counter shared by the fetch and data-memory phases; flags when a
// request has been outstanding for MEM_TIMEOUT cycles.
module cpu_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/cpu_multicycle_sequencer.sv
// Multi-cycle MIPS control FSM: walks each instruction through
// fetch/decode/execute/memory/writeback and drives datapath controls per phase.
module cpu_multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] cpu_opcode,
    input  logic       alu_zero,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_rd,
    output logic       dmem_wr,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       reg_wr,
    output logic [1:0] dest_reg,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_opcode,
    output logic       alu_src,
    output logic       sign_or_zero,
    output logic       instr_done,
    output logic       bus_err,
    output logic [2:0] dbg_state
);

    logic [2:0] state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       done;
    logic       wait_enable, wait_clear, wait_expired;
    alu_ctl_t   alu;

    cpu_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wait_clear),
        .enable_i  (wait_enable),
        .expired_o (wait_expired)
    );

    // Every entry into FETCH or MEM is a state change, so that restarts the count.
    assign wait_clear = (state_d != state_q);
    assign alu        = alu_ctl(op_q);
    assign dbg_state  = state_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        done        = 1'b0;
        wait_enable = 1'b0;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else begin
                    wait_enable = 1'b1;
                    if (wait_expired) state_d = S_ERR;
                end
            end
            S_DECODE: begin
                op_d    = cpu_opcode;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_J, OP_BEQ: done = 1'b1;
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op_q == OP_LW) state_d = S_WB;
                    else               done = 1'b1;
                end else begin
                    wait_enable = 1'b1;
                    if (wait_expired) state_d = S_ERR;
                end
            end
            S_WB:     done = 1'b1;
            default:  state_d = S_ERR;
        endcase
        if (done) state_d = run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        imem_req     = 1'b0;
        dmem_rd      = 1'b0;
        dmem_wr      = 1'b0;
        ir_wr        = 1'b0;
        pc_wr        = 1'b0;
        pc_src       = PC_PLUS1;
        reg_wr       = 1'b0;
        dest_reg     = DST_RT;
        mem_to_reg   = M2R_ALU;
        alu_opcode   = ALU_ADD;
        alu_src      = 1'b0;
        sign_or_zero = 1'b1;
        instr_done   = done;
        bus_err      = (state_q == S_ERR);
        // ALU controls stay stable from EXEC until the instruction retires.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_opcode   = alu.op;
            alu_src      = alu.src;
            sign_or_zero = alu.sext;
        end
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_wr  = 1'b1;
                    pc_wr  = 1'b1;
                    pc_src = PC_PLUS1;
                end
            end
            S_EXEC: begin
                if (op_q == OP_J) begin
                    pc_wr  = 1'b1;
                    pc_src = PC_JUMP;
                end else if (op_q == OP_BEQ) begin
                    pc_wr  = alu_zero;
                    pc_src = PC_BRANCH;
                end
            end
            S_MEM: begin
                dmem_rd = (op_q == OP_LW);
                dmem_wr = (op_q == OP_SW);
            end
            S_WB: begin
                reg_wr = 1'b1;
                case (op_q)
                    OP_ADD: dest_reg = DST_RD;
                    OP_LW:  mem_to_reg = M2R_MEM;
                    OP_JAL: begin
                        dest_reg   = DST_LINK;
                        mem_to_reg = M2R_PC;
                        pc_wr      = 1'b1;
                        pc_src     = PC_JUMP;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_multicycle_sequencer.sv
// Directed and randomized checks of the multi-cycle sequencer against a
// phase-level model that expands each instruction into expected cycles.
module tb_cpu_multicycle_sequencer;
    import cpu_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_rd;
        logic       dmem_wr;
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       reg_wr;
        logic [1:0] dest_reg;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_opcode;
        logic       alu_src;
        logic       sign_or_zero;
        logic       instr_done;
        logic       bus_err;
    } ctl_t;

    typedef struct packed {
        logic       run;
        logic       ia;
        logic       da;
        logic       az;
        logic [2:0] opc;
        ctl_t       e;
        logic [2:0] st;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [2:0] cpu_opcode;
    logic       alu_zero, imem_ack, dmem_ack;
    logic       imem_req, dmem_rd, dmem_wr, ir_wr, pc_wr, reg_wr;
    logic [1:0] pc_src, dest_reg, mem_to_reg, alu_opcode;
    logic       alu_src, sign_or_zero, instr_done, bus_err;
    logic [2:0] dbg_state;
    ctl_t       obs;

    int    checks = 0;
    int    errors = 0;
    int    step_no = 0;
    bit    at_idle = 1'b1;
    step_t exp_q[$];

    always #5 clk = ~clk;

    cpu_multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run(run), .cpu_opcode(cpu_opcode), .alu_zero(alu_zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_rd(dmem_rd),
        .dmem_wr(dmem_wr), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr),
        .dest_reg(dest_reg), .mem_to_reg(mem_to_reg), .alu_opcode(alu_opcode),
        .alu_src(alu_src), .sign_or_zero(sign_or_zero), .instr_done(instr_done),
        .bus_err(bus_err), .dbg_state(dbg_state)
    );

    assign obs = {imem_req, dmem_rd, dmem_wr, ir_wr, pc_wr, pc_src, reg_wr, dest_reg,
                  mem_to_reg, alu_opcode, alu_src, sign_or_zero, instr_done, bus_err};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] rop();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic ctl_t quiet();
        ctl_t c = '0;
        c.sign_or_zero = 1'b1;
        return c;
    endfunction

    function automatic ctl_t with_alu(input logic [2:0] op);
        ctl_t c = quiet();
        case (op)
            OP_ADD:               begin c.alu_opcode = 2'b00; c.alu_src = 1'b0; c.sign_or_zero = 1'b1; end
            OP_SLI:               begin c.alu_opcode = 2'b10; c.alu_src = 1'b1; c.sign_or_zero = 1'b0; end
            OP_BEQ:               begin c.alu_opcode = 2'b01; c.alu_src = 1'b0; c.sign_or_zero = 1'b1; end
            OP_LW, OP_SW, OP_ADDI: begin c.alu_opcode = 2'b11; c.alu_src = 1'b1; c.sign_or_zero = 1'b1; end
            default:              begin c.alu_opcode = 2'b00; c.alu_src = 1'b0; c.sign_or_zero = 1'b1; end
        endcase
        return c;
    endfunction

    task automatic push(input logic r, input logic ia, input logic da, input logic az,
                        input logic [2:0] opc, input ctl_t e, input logic [2:0] st);
        step_t s;
        s.run = r; s.ia = ia; s.da = da; s.az = az; s.opc = opc; s.e = e; s.st = st;
        exp_q.push_back(s);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), rb(), rop(), quiet(), S_IDLE);
    endtask

    task automatic err_steps(input int n);
        ctl_t e = quiet();
        e.bus_err = 1'b1;
        for (int i = 0; i < n; i++) push(rb(), rb(), rb(), rb(), rop(), e, S_ERR);
    endtask

    // fw/mw: cycles without ack before the ack; a value >= TO means the ack never comes.
    task automatic add_instr(input logic [2:0] op, input int fw, input int mw,
                             input logic zero, input logic run_after);
        ctl_t e;
        bit   mem_op = (op == OP_LW) || (op == OP_SW);
        if (at_idle) push(1'b1, rb(), rb(), rb(), rop(), quiet(), S_IDLE);
        at_idle = !run_after;
        e = quiet();
        e.imem_req = 1'b1;
        for (int i = 0; i < ((fw >= TO) ? TO : fw); i++) push(rb(), 1'b0, rb(), rb(), rop(), e, S_FETCH);
        if (fw >= TO) begin
            err_steps(22);
            return;
        end
        e.ir_wr = 1'b1; e.pc_wr = 1'b1; e.pc_src = 2'b00;
        push(rb(), 1'b1, rb(), rb(), rop(), e, S_FETCH);
        push(rb(), rb(), rb(), rb(), op, quiet(), S_DECODE);
        e = with_alu(op);
        if (op == OP_J || op == OP_BEQ) begin
            e.pc_wr = (op == OP_J) ? 1'b1 : zero;
            e.pc_src = (op == OP_J) ? 2'b01 : 2'b10;
            e.instr_done = 1'b1;
            push(run_after, rb(), rb(), zero, rop(), e, S_EXEC);
            return;
        end
        push(rb(), rb(), rb(), zero, rop(), e, S_EXEC);
        if (mem_op) begin
            e = with_alu(op);
            e.dmem_rd = (op == OP_LW);
            e.dmem_wr = (op == OP_SW);
            for (int i = 0; i < ((mw >= TO) ? TO : mw); i++) push(rb(), rb(), 1'b0, rb(), rop(), e, S_MEM);
            if (mw >= TO) begin
                err_steps(22);
                return;
            end
            if (op == OP_SW) begin
                e.instr_done = 1'b1;
                push(run_after, rb(), 1'b1, rb(), rop(), e, S_MEM);
                return;
            end
            push(rb(), rb(), 1'b1, rb(), rop(), e, S_MEM);
        end
        e = with_alu(op);
        e.reg_wr = 1'b1;
        e.instr_done = 1'b1;
        case (op)
            OP_ADD: e.dest_reg = 2'b01;
            OP_LW:  e.mem_to_reg = 2'b01;
            OP_JAL: begin e.dest_reg = 2'b10; e.mem_to_reg = 2'b10; e.pc_wr = 1'b1; e.pc_src = 2'b01; end
            default: ;
        endcase
        push(run_after, rb(), rb(), rb(), rop(), e, S_WB);
    endtask

    task automatic check(input string tag, input ctl_t exp_c, input logic [2:0] exp_st);
        checks++;
        assert (obs === exp_c) else begin
            errors++;
            $error("FAIL %s ctl: observed %h expected %h", tag, obs, exp_c);
        end
        checks++;
        assert (dbg_state === exp_st) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", tag, dbg_state, exp_st);
        end
    endtask

    // Entered and left at posedge+1: drive inputs, sample at negedge.
    task automatic play(input int limit);
        step_t s;
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            s = exp_q.pop_front();
            run = s.run; imem_ack = s.ia; dmem_ack = s.da; alu_zero = s.az; cpu_opcode = s.opc;
            @(negedge clk);
            check($sformatf("step%0d", step_no), s.e, s.st);
            step_no++;
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        ctl_t e;
        rst = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        check({tag, "_async"}, quiet(), S_IDLE);
        @(negedge clk);
        check({tag, "_held"}, quiet(), S_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        at_idle = 1'b1;
        e = quiet();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; cpu_opcode = '0; alu_zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset");
        idle_steps(3);
        play(1000);

        add_instr(OP_ADD, 0, 0, 1'b0, 1'b1);
        add_instr(OP_LW, 0, 3, 1'b0, 1'b1);
        add_instr(OP_BEQ, 0, 0, 1'b1, 1'b1);
        add_instr(OP_BEQ, 0, 0, 1'b0, 1'b1);
        add_instr(OP_JAL, 1, 0, 1'b0, 1'b1);
        add_instr(OP_J, 2, 0, 1'b1, 1'b1);
        add_instr(OP_SLI, 0, 0, 1'b0, 1'b1);
        add_instr(OP_ADDI, 0, 0, 1'b0, 1'b1);
        add_instr(OP_SW, 0, 2, 1'b0, 1'b0);
        idle_steps(2);
        add_instr(OP_ADD, 3, 0, 1'b0, 1'b1);
        add_instr(OP_LW, 0, 3, 1'b0, 1'b1);
        add_instr(OP_SW, 3, 3, 1'b0, 1'b0);
        play(1000);

        for (int i = 0; i < 60; i++) begin
            logic ra = ($urandom_range(0, 3) != 0);
            add_instr(rop(), $urandom_range(0, 3), $urandom_range(0, 3), rb(), ra);
            if (!ra) idle_steps($urandom_range(0, 2));
        end
        play(5000);

        add_instr(OP_LW, 0, 3, 1'b0, 1'b1);
        play(5);
        do_reset("rst_mid_mem");
        idle_steps(1);
        play(10);

        add_instr(OP_ADD, TO, 0, 1'b0, 1'b1);
        play(100);
        do_reset("rst_after_fetch_err");

        add_instr(OP_SW, 0, TO, 1'b0, 1'b1);
        play(100);
        do_reset("rst_after_sw_err");

        add_instr(OP_LW, 1, TO, 1'b0, 1'b1);
        play(100);
        do_reset("rst_after_lw_err");

        add_instr(OP_JAL, 0, 0, 1'b0, 1'b0);
        idle_steps(2);
        play(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_multicycle_sequencer.md
Name: cpu_multicycle_sequencer

Overview:
Multi-cycle control FSM for the MIPS processor. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath control lines once per phase. It handshakes with instruction and data memory (req/ack) and bounds every memory wait with a timeout. It sits between the instruction register opcode field and the shared single-ported datapath and memories.

Parameters:
MEM_TIMEOUT, 16, maximum cycles any memory request may wait for ack before a bus error is raised (must be ≥2).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  enable; sampled only at instruction boundaries
cpu_opcode  input  3  opcode field of instruction register
alu_zero  input  1  ALU zero flag (beq)
imem_ack  input  1  instruction memory data valid / IR load
dmem_ack  input  1  data memory read data valid or write accepted
imem_req  output  1  instruction fetch request
dmem_rd  output  1  data memory read request
dmem_wr  output  1  data memory write request
ir_wr  output  1  load instruction register
pc_wr  output  1  load PC
pc_src  output  2  00 PC+1, 01 jump target, 10 branch target
reg_wr  output  1  register file write enable
dest_reg  output  2  00 rt, 01 rd, 10 r7 (link)
mem_to_reg  output  2  00 ALU, 01 memory data, 10 PC
alu_opcode  output  2  ALU operation select
alu_src  output  1  0 register, 1 immediate
sign_or_zero  output  1  1 sign-extend immediate, 0 zero-extend
instr_done  output  1  pulse in final cycle of each instruction
bus_err  output  1  sticky memory timeout flag

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR. rst forces IDLE asynchronously, clears op_q, wait counter and bus_err.
- Reset/IDLE outputs: all 0 except sign_or_zero=1. No request is ever active in IDLE.
- IDLE: run=1 -> FETCH.
- FETCH: imem_req=1 held until imem_ack. Ack cycle: ir_wr=1, pc_wr=1, pc_src=00 -> DECODE.
- DECODE: one cycle. Latch cpu_opcode into op_q. All later phases decode op_q, never cpu_opcode.
- EXEC: alu_opcode/alu_src/sign_or_zero per op_q, held constant from EXEC to end of instruction:
  - add (000): 00/0/1
  - sli (001): 10/1/0
  - beq (110): 01/0/1
  - lw/sw/addi (100/101/111): 11/1/1
  - j (010), jal (011): 00/0/1
- EXEC next state:
  - add, sli, addi, jal -> WB
  - lw, sw -> MEM
  - j: pc_wr=1, pc_src=01; end of instruction
  - beq: pc_wr=alu_zero, pc_src=10; end of instruction
- MEM: lw holds dmem_rd=1; on dmem_ack -> WB. sw holds dmem_wr=1; on dmem_ack, end of instruction. dmem_rd and dmem_wr are never both high.
- WB: reg_wr=1 for exactly one cycle.
  - add: dest 01, m2r 00
  - sli/addi: dest 00, m2r 00
  - lw: dest 00, m2r 01
  - jal: dest 10, m2r 10, plus pc_wr=1, pc_src=01. The link value is the pre-edge PC, i.e. PC+1.
  - End of instruction.
- End of instruction: instr_done=1 that cycle. Next state is FETCH if run=1, else IDLE. Deasserting run never aborts an instruction mid-flight.
- Latency with zero-wait ack (FETCH ack in first cycle):
  - j, beq: 3 cycles
  - add, sli, addi, jal, sw: 4 cycles
  - lw: 5 cycles
  - Each wait cycle adds 1.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - Reaching MEM_TIMEOUT-1 with no ack -> ERR; that cycle still shows the request.
  - Ack in the same cycle as the limit: ack wins.
  - Acks arriving when no request is active are ignored.
- ERR: all controls 0, sign_or_zero=1, bus_err=1. Exit only by rst.
- Unused encodings: none. All 8 opcodes are defined.

Decomposition:
- Package cpu_pkg:
  - state enum
  - opcode localparams (OP_ADD..OP_ADDI)
  - pc_src, dest_reg, mem_to_reg encodings
  - ALU op encodings
- Sub-module cpu_mem_wait_timer: clear/enable/expired, parameterised by MEM_TIMEOUT. One instance is shared by FETCH and MEM.

Test Plan:
- rst pulse mid-MEM during lw -> next cycle state IDLE, dmem_rd=0, sign_or_zero=1, bus_err=0.
- run=1, add, immediate acks -> ir_wr@c1, reg_wr with dest 01 @c4, instr_done@c4, imem_req@c5.
- lw with dmem_ack after 3 wait cycles -> dmem_rd high 4 cycles, then WB reg_wr=1, m2r 01, total 8 cycles.
- beq with alu_zero=1 then =0 -> pc_wr=1 pc_src=10 in EXEC for the first, pc_wr=0 for the second; no reg_wr either way.
- jal -> WB cycle has reg_wr=1, dest 10, m2r 10, pc_wr=1, pc_src=01 simultaneously.
- imem_ack withheld, MEM_TIMEOUT=4 -> imem_req high 4 cycles, then ERR with bus_err=1 held 20+ cycles; ack with limit (3rd stall) -> DECODE, no error; run=0 during sw completes sw then IDLE.
